uart_tx_ser: RTL and testbench

UART_TX_SER -- requirements
Module: uart_tx_ser

---
 rtl/uart_tx_ser_pkg.sv | 17 +
 rtl/uart_tx_ser.sv | 121 ++++++++++++
 tb/tb_uart_tx_ser.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ser_pkg.sv
// Shared definitions for the UART serialiser: FSM encoding, data width
// and the index of the last data bit.
package uart_tx_ser_pkg;

    localparam int DATA_W = 8;
    localparam logic [2:0] BIT_LAST = 3'd7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_e;

endpackage

// File: rtl/uart_tx_ser.sv
// UART transmit serialiser: frames a byte as start, 8 data bits LSB first,
// optional even parity and stop, advancing one bit per txen pulse.
module uart_tx_ser
    import uart_tx_ser_pkg::*;
#(
    parameter bit PARITY_EN = 1'b0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              txen,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              txd
);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              par_q, par_d;
    logic              txd_q, txd_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tx_start) state_d = ARM;
            ARM:     if (txen)     state_d = START;
            START:   if (txen)     state_d = DATA;
            DATA: begin
                if (txen && (cnt_q == BIT_LAST)) begin
                    state_d = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY:  if (txen)     state_d = STOP;
            STOP:    if (txen)     state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Line value, shift register and bit counter only move on txen, so the
    // frame stretches or freezes with whatever cadence the baud block gives.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        txd_d   = txd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (tx_start) begin
                    shreg_d = tx_data;
                    par_d   = ^tx_data;
                    cnt_d   = 3'd0;
                end
            end
            ARM: begin
                if (txen) txd_d = 1'b0;
            end
            START: begin
                if (txen) begin
                    txd_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    cnt_d   = 3'd0;
                end
            end
            DATA: begin
                if (txen) begin
                    if (cnt_q == BIT_LAST) begin
                        txd_d = PARITY_EN ? par_q : 1'b1;
                    end else begin
                        txd_d   = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (txen) txd_d = 1'b1;
            end
            STOP: begin
                if (txen) begin
                    txd_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shreg_q <= '0;
            cnt_q   <= 3'd0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    assign txd     = txd_q;
    assign tx_done = done_q;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_ser.sv
// Bench for uart_tx_ser: runs a plain and a parity instance side by side
// against a frame-level reference model, plus literal frame checks.
module tb_uart_tx_ser;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       txen;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [1:0] txd, tx_busy, tx_done;

    uart_tx_ser #(.PARITY_EN(1'b0)) dut0 (
        .clk(clk), .n_rst(n_rst), .txen(txen), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .txd(txd[0]));
    uart_tx_ser #(.PARITY_EN(1'b1)) dut1 (
        .clk(clk), .n_rst(n_rst), .txen(txen), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .txd(txd[1]));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is a list of line bits; the k-th txen after
    // acceptance puts bit k-1 on the line, one txen past the last bit ends it.
    bit   m_active[2];
    int   m_k[2];
    int   m_n[2];
    logic m_bits[2][0:10];
    logic m_done[2];

    function automatic logic m_txd(input int i);
        if (!m_active[i] || m_k[i] == 0) return 1'b1;
        return m_bits[i][m_k[i]-1];
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0; m_k[i] = 0; m_done[i] = 0; m_n[i] = 10;
        end
        forever begin
            @(posedge clk or negedge n_rst);
            for (int i = 0; i < 2; i++) begin
                if (!n_rst) begin
                    m_active[i] = 0; m_k[i] = 0; m_done[i] = 0;
                end else begin
                    m_done[i] = 0;
                    if (!m_active[i]) begin
                        if (tx_start) begin
                            m_n[i] = (i == 1) ? 11 : 10;
                            m_bits[i][0] = 1'b0;
                            for (int b = 0; b < 8; b++) m_bits[i][b+1] = tx_data[b];
                            if (i == 1) begin
                                m_bits[i][9]  = ^tx_data;
                                m_bits[i][10] = 1'b1;
                            end else begin
                                m_bits[i][9]  = 1'b1;
                                m_bits[i][10] = 1'b1;
                            end
                            m_active[i] = 1; m_k[i] = 0;
                        end
                    end else if (txen) begin
                        m_k[i]++;
                        if (m_k[i] > m_n[i]) begin
                            m_active[i] = 0; m_done[i] = 1;
                        end
                    end
                end
            end
        end
    end

    // txen source: 0 = every 16 clk, 1 = random 1-in-4, 2 = held off
    int txen_mode = 0;
    int div = 0;
    initial begin
        txen = 1'b0;
        forever begin
            @(negedge clk);
            case (txen_mode)
                0: begin
                    if (div == 15) begin txen = 1'b1; div = 0; end
                    else begin txen = 1'b0; div++; end
                end
                1: txen = ($urandom_range(0, 3) == 0);
                default: txen = 1'b0;
            endcase
        end
    end

    // per-cycle compare and line recorder
    bit   rec_en = 0;
    int   rec_len = 0;
    logic rec_txd[2][0:1023];
    int   done_cnt[2];
    int   done_idx[2][0:3];

    initial begin
        done_cnt[0] = 0; done_cnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("txd%0d", i), txd[i], m_txd(i));
                chk($sformatf("busy%0d", i), tx_busy[i], m_active[i]);
                chk($sformatf("done%0d", i), tx_done[i], m_done[i]);
            end
            if (rec_en && rec_len < 1024) begin
                for (int i = 0; i < 2; i++) begin
                    rec_txd[i][rec_len] = txd[i];
                    if (tx_done[i]) begin
                        if (done_cnt[i] < 4) done_idx[i][done_cnt[i]] = rec_len;
                        done_cnt[i]++;
                    end
                end
                rec_len++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic rec_start();
        rec_len = 0; done_cnt[0] = 0; done_cnt[1] = 0; rec_en = 1;
    endtask

    task automatic start_pulse(input logic [7:0] d);
        tx_data = d; tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while (tx_busy != 2'b00 && c < budget) begin tick(1); c++; end
        if (c >= budget) chk({name, "_timeout"}, tx_busy, 0);
    endtask

    task automatic wait_fall(input string name);
        int c = 0;
        while (txd[0] !== 1'b0 && c < 100) begin tick(1); c++; end
        if (c >= 100) chk({name, "_fall_timeout"}, txd[0], 0);
    endtask

    // Mid-bit samples of a recorded frame (txen every 16 clk) and its length
    // from the falling edge to the tx_done pulse.
    task automatic analyze(input int inst, input int from, input logic [0:10] exp,
                           input int n, input string name, output int f, output int d);
        logic [10:0] gv, ev;
        f = -1; d = -1;
        for (int j = from; j < rec_len; j++) begin
            if (rec_txd[inst][j] == 1'b0) begin f = j; break; end
        end
        gv = '0; ev = '0;
        for (int b = 0; b < n; b++) begin
            ev[b] = exp[b];
            gv[b] = (f >= 0 && f + 16*b + 8 < rec_len) ? rec_txd[inst][f + 16*b + 8] : 1'bx;
        end
        chk({name, "_bits"}, gv, ev);
        for (int k = 0; k < done_cnt[inst] && k < 4; k++) begin
            if (done_idx[inst][k] > f) begin d = done_idx[inst][k]; break; end
        end
        chk({name, "_len"}, d - f, 16 * n);
    endtask

    initial begin
        int f, d, s, c;
        n_rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
        #1 n_rst = 1'b0;
        #1;
        chk("rst_txd", txd, 2'b11);
        chk("rst_busy", tx_busy, 2'b00);
        chk("rst_done", tx_done, 2'b00);
        tick(3);
        n_rst = 1'b1;
        tick(5);

        // basic frame, 8'hA5
        rec_start();
        start_pulse(8'hA5);
        wait_idle("a5", 400);
        tick(2);
        analyze(0, 0, 11'b0101001011_0, 10, "a5_p0", f, d);
        analyze(1, 0, 11'b01010010101, 11, "a5_p1", f, d);
        chk("a5_done_cnt", done_cnt[0], 1);
        chk("a5_busy_after", tx_busy[0], 0);

        // parity: 07 -> 1, 03 -> 0
        rec_start();
        start_pulse(8'h07);
        wait_idle("p07", 400);
        tick(2);
        analyze(1, 0, 11'b01110000011, 11, "p07_p1", f, d);
        analyze(0, 0, 11'b0111000001_0, 10, "p07_p0", f, d);
        rec_start();
        start_pulse(8'h03);
        wait_idle("p03", 400);
        tick(2);
        analyze(1, 0, 11'b01100000001, 11, "p03_p1", f, d);

        // tx_start coinciding with txen: that txen must not start the frame
        rec_start();
        c = 0;
        while (txen !== 1'b1 && c < 40) begin tick(1); c++; end
        chk("coinc_txen_seen", txen, 1'b1);
        s = rec_len;
        tx_data = 8'h3C; tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        wait_idle("coinc", 400);
        tick(2);
        analyze(0, 0, 11'b0001111001_0, 10, "coinc", f, d);
        chk("coinc_arm_wait", f - s, 16);

        // tx_start held through the frame, data changed mid-frame
        rec_start();
        tx_data = 8'h55; tx_start = 1'b1;
        tick(80);
        tx_data = 8'hFF;
        c = 0;
        while ((done_cnt[0] < 1 || done_cnt[1] < 1) && c < 400) begin tick(1); c++; end
        chk("hold_first_done", done_cnt[1] >= 1, 1'b1);
        tick(1);
        tx_start = 1'b0;
        wait_idle("hold", 400);
        tick(2);
        chk("hold_done_cnt0", done_cnt[0], 2);
        chk("hold_done_cnt1", done_cnt[1], 2);
        analyze(0, 0, 11'b0101010101_0, 10, "hold55_p0", f, d);
        analyze(0, d, 11'b0111111111_0, 10, "holdff_p0", f, d);
        analyze(1, 0, 11'b01010101001, 11, "hold55_p1", f, d);
        analyze(1, d, 11'b01111111101, 11, "holdff_p1", f, d);

        // asynchronous reset during data bit 3
        rec_start();
        start_pulse(8'hC3);
        wait_fall("rst_mid");
        tick(70);
        #2 n_rst = 1'b0;
        #1;
        chk("rstmid_txd", txd, 2'b11);
        chk("rstmid_busy", tx_busy, 2'b00);
        tick(3);
        n_rst = 1'b1;
        tick(40);
        chk("rstmid_no_done", done_cnt[0] + done_cnt[1], 0);
        chk("rstmid_idle", tx_busy, 2'b00);
        rec_start();
        start_pulse(8'hC3);
        wait_idle("rst_after", 400);
        tick(2);
        analyze(0, 0, 11'b0110000111_0, 10, "rst_after", f, d);

        // txen stalled for 100 clk during data bit 2 (a '1' for 8'hA5)
        rec_start();
        start_pulse(8'hA5);
        wait_fall("freeze");
        tick(52);
        txen_mode = 2;
        for (int j = 0; j < 4; j++) begin
            tick(25);
            chk("freeze_txd0", txd[0], 1'b1);
            chk("freeze_busy", tx_busy, 2'b11);
        end
        txen_mode = 0;
        wait_idle("freeze", 400);
        tick(2);
        chk("freeze_done_cnt", done_cnt[0], 1);

        // random traffic, irregular txen, data churning every clk
        rec_en = 0;
        for (int r = 0; r < 3000; r++) begin
            if (r % 500 == 0) txen_mode = $urandom_range(0, 1);
            tx_start = ($urandom_range(0, 7) == 0);
            tx_data  = 8'($urandom);
            tick(1);
        end
        tx_start = 1'b0;
        txen_mode = 0;
        wait_idle("rand", 1000);
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
